xosera_bus_bridge: RTL and testbench

- Sequencer between the CPU memory-mapped bus and the 8-bit Xosera register bus (xosera_main).
- Converts one 16-bit CPU register access into two timed byte cycles on the Xosera bus: high byte (bytesel=0) first, then low byte (bytesel=1).
- Drives chip-select, read/not-write, register number, bytesel and data with programmable setup, strobe and hold widths.
- Replaces software bit-banging of the strobe through separate select, data and strobe addresses.

---
 rtl/xosera_bus_bridge.sv | 128 ++++++++++++
 tb/tb_xosera_bus_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xosera_bus_bridge.sv
// Turns one 16-bit CPU register access into two timed byte cycles on the 8-bit Xosera bus.
// The high byte goes first. Setup, strobe and hold widths are set by parameters.
module xosera_bus_bridge #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic        cpu_byte,
    input  logic [3:0]  cpu_reg,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_overrun,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    input  logic [7:0]  bus_data_i
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

    state_t     state;
    logic [7:0] phase_cnt;
    logic       write_q;
    logic       byte_q;
    logic [7:0] lo_wdata_q;
    logic [7:0] rd_hi_q;
    logic [7:0] rd_lo_q;

    // bus_bytesel_o doubles as the byte index: 0 means a second (low) byte is still pending
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            write_q       <= 1'b0;
            byte_q        <= 1'b0;
            lo_wdata_q    <= '0;
            rd_hi_q       <= '0;
            rd_lo_q       <= '0;
            cpu_rdata     <= '0;
            cpu_busy      <= 1'b0;
            cpu_done      <= 1'b0;
            cpu_overrun   <= 1'b0;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_reg_num_o <= '0;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= '0;
        end else begin
            cpu_done <= 1'b0;
            if (cpu_req && state != IDLE)
                cpu_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        write_q       <= cpu_write;
                        byte_q        <= cpu_byte;
                        lo_wdata_q    <= cpu_wdata[7:0];
                        bus_reg_num_o <= cpu_reg;
                        bus_bytesel_o <= cpu_byte;
                        bus_data_o    <= cpu_byte ? cpu_wdata[7:0] : cpu_wdata[15:8];
                        bus_rd_nwr_o  <= ~cpu_write;
                        cpu_busy      <= 1'b1;
                        phase_cnt     <= SETUP_LOAD;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == '0) begin
                        bus_cs_n_o <= 1'b0;
                        phase_cnt  <= STROBE_LOAD;
                        state      <= STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (phase_cnt == '0) begin
                        bus_cs_n_o <= 1'b1;
                        if (!write_q) begin
                            if (bus_bytesel_o)
                                rd_lo_q <= bus_data_i;
                            else
                                rd_hi_q <= bus_data_i;
                        end
                        phase_cnt <= HOLD_LOAD;
                        state     <= HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == '0) begin
                        if (!bus_bytesel_o) begin
                            bus_bytesel_o <= 1'b1;
                            bus_data_o    <= lo_wdata_q;
                            phase_cnt     <= SETUP_LOAD;
                            state         <= SETUP;
                        end else begin
                            if (!write_q)
                                cpu_rdata <= byte_q ? {8'h00, rd_lo_q} : {rd_hi_q, rd_lo_q};
                            bus_rd_nwr_o <= 1'b1;
                            cpu_busy     <= 1'b0;
                            cpu_done     <= 1'b1;
                            state        <= IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xosera_bus_bridge.sv
// Directed bench for xosera_bus_bridge. A cycle model checks the bus waveform, and a scoreboard
// queue holds the expected read words. Instance a uses the default timing, instance b uses 2/3/2.
module tb_xosera_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b1;
    logic        cpu_write = 1'b1;
    logic        cpu_byte = 1'b0;
    logic [3:0]  cpu_reg = 4'hF;
    logic [15:0] cpu_wdata = 16'hFFFF;
    logic [7:0]  bus_data_i = 8'hEE;

    logic [15:0] a_rdata, b_rdata;
    logic        a_busy, a_done, a_ovr, a_cs_n, a_rd_nwr, a_bytesel;
    logic        b_busy, b_done, b_ovr, b_cs_n, b_rd_nwr, b_bytesel;
    logic [3:0]  a_reg, b_reg;
    logic [7:0]  a_data, b_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];
    logic        exp_ovr = 1'b0;
    logic        m_write, m_byte;
    logic [3:0]  m_reg;
    logic [15:0] m_wdata, m_rd;

    always #5 clk = ~clk;

    xosera_bus_bridge dut_a (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_byte(cpu_byte),
        .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata), .cpu_busy(a_busy),
        .cpu_done(a_done), .cpu_overrun(a_ovr), .bus_cs_n_o(a_cs_n), .bus_rd_nwr_o(a_rd_nwr),
        .bus_reg_num_o(a_reg), .bus_bytesel_o(a_bytesel), .bus_data_o(a_data), .bus_data_i(bus_data_i)
    );

    xosera_bus_bridge #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_byte(cpu_byte),
        .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata), .cpu_busy(b_busy),
        .cpu_done(b_done), .cpu_overrun(b_ovr), .bus_cs_n_o(b_cs_n), .bus_rd_nwr_o(b_rd_nwr),
        .bus_reg_num_o(b_reg), .bus_bytesel_o(b_bytesel), .bus_data_o(b_data), .bus_data_i(bus_data_i)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic getObs(input int sel, output logic cs, output logic rn, output logic bs,
                          output logic by, output logic dn, output logic ov,
                          output logic [3:0] rg, output logic [7:0] d, output logic [15:0] rd);
        cs = sel ? b_cs_n : a_cs_n;     rn = sel ? b_rd_nwr : a_rd_nwr;
        bs = sel ? b_bytesel : a_bytesel; by = sel ? b_busy : a_busy;
        dn = sel ? b_done : a_done;     ov = sel ? b_ovr : a_ovr;
        rg = sel ? b_reg : a_reg;       d  = sel ? b_data : a_data;
        rd = sel ? b_rdata : a_rdata;
    endtask

    // Call right after a negedge. The request is sampled at the next posedge (edge 0).
    task automatic applyStimulus(input logic wr, input logic by, input logic [3:0] rg,
                                 input logic [15:0] wd, input logic [15:0] rd);
        cpu_req = 1'b1; cpu_write = wr; cpu_byte = by; cpu_reg = rg; cpu_wdata = wd;
        m_write = wr; m_byte = by; m_reg = rg; m_wdata = wd; m_rd = rd;
        if (!wr) sb_q.push_back(by ? {8'h00, rd[7:0]} : rd);
    endtask

    // Walks cycles 1..done, returning at the negedge of the done cycle.
    // A nonzero ovr_cycle raises a stray request during that cycle.
    task automatic checkOutput(input int sel, input int s, input int t, input int h, input int ovr_cycle);
        int p, nb, done_k, b, o, bsel;
        logic strobe;
        logic cs, rn, bs, by, dn, ov;
        logic [3:0] rg;
        logic [7:0] d;
        logic [15:0] rd, exp_rd;
        p = s + t + h;
        nb = m_byte ? 1 : 2;
        done_k = nb * p + 1;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            if (k == 1 || k == ovr_cycle + 1) cpu_req = 1'b0;
            getObs(sel, cs, rn, bs, by, dn, ov, rg, d, rd);
            if (k < done_k) begin
                b = (k - 1) / p;
                o = (k - 1) % p;
                strobe = (o >= s) && (o < s + t);
                bsel = m_byte ? 1 : b;
                chk($sformatf("cs_n c%0d", k), cs, !strobe);
                chk($sformatf("bytesel c%0d", k), bs, bsel[0]);
                chk($sformatf("data_o c%0d", k), d, bsel ? m_wdata[7:0] : m_wdata[15:8]);
                chk($sformatf("reg c%0d", k), rg, m_reg);
                chk($sformatf("rd_nwr c%0d", k), rn, !m_write);
                chk($sformatf("busy c%0d", k), by, 1'b1);
                chk($sformatf("done c%0d", k), dn, 1'b0);
                bus_data_i = (o == s + t - 1) ? (bsel ? m_rd[7:0] : m_rd[15:8]) : 8'hEE;
            end else begin
                bus_data_i = 8'hEE;
                chk("done pulse", dn, 1'b1);
                chk("busy at done", by, 1'b0);
                chk("cs_n at done", cs, 1'b1);
                chk("rd_nwr at done", rn, 1'b1);
                chk("overrun", ov, exp_ovr);
                if (!m_write) begin
                    if (sb_q.size() == 0) begin
                        chk("scoreboard empty", 16'h0000, 16'h0001);
                    end else begin
                        exp_rd = sb_q.pop_front();
                        chk("cpu_rdata", rd, exp_rd);
                    end
                end
            end
            if (k == ovr_cycle) begin
                cpu_req = 1'b1; cpu_write = 1'b1; cpu_reg = 4'h0; cpu_wdata = 16'h0000;
                exp_ovr = 1'b1;
            end
        end
    endtask

    task automatic checkIdle(input int sel, input logic [15:0] exp_rd);
        logic cs, rn, bs, by, dn, ov;
        logic [3:0] rg;
        logic [7:0] d;
        logic [15:0] rd;
        @(negedge clk);
        getObs(sel, cs, rn, bs, by, dn, ov, rg, d, rd);
        chk("idle done", dn, 1'b0);
        chk("idle busy", by, 1'b0);
        chk("idle cs_n", cs, 1'b1);
        chk("idle rdata held", rd, exp_rd);
    endtask

    task automatic checkReset(input int sel);
        logic cs, rn, bs, by, dn, ov;
        logic [3:0] rg;
        logic [7:0] d;
        logic [15:0] rd;
        getObs(sel, cs, rn, bs, by, dn, ov, rg, d, rd);
        chk("rst cs_n", cs, 1'b1);
        chk("rst rd_nwr", rn, 1'b1);
        chk("rst reg", rg, 4'h0);
        chk("rst bytesel", bs, 1'b0);
        chk("rst data_o", d, 8'h00);
        chk("rst rdata", rd, 16'h0000);
        chk("rst busy", by, 1'b0);
        chk("rst done", dn, 1'b0);
        chk("rst overrun", ov, 1'b0);
    endtask

    initial begin
        // Reset held for two edges while a request is pending
        repeat (2) begin
            @(negedge clk);
            checkReset(0);
            checkReset(1);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        checkIdle(0, 16'h0000);

        applyStimulus(1'b1, 1'b0, 4'h3, 16'hA55A, 16'h0000);
        checkOutput(0, 1, 2, 1, 0);
        checkIdle(0, 16'h0000);

        applyStimulus(1'b0, 1'b0, 4'h7, 16'h0000, 16'h1234);
        checkOutput(0, 1, 2, 1, 0);
        checkIdle(0, 16'h1234);

        // Byte write, then a byte read accepted in the done cycle
        applyStimulus(1'b1, 1'b1, 4'hA, 16'hFF3C, 16'h0000);
        checkOutput(0, 1, 2, 1, 0);
        applyStimulus(1'b0, 1'b1, 4'h2, 16'h0000, 16'h00C3);
        checkOutput(0, 1, 2, 1, 0);
        checkIdle(0, 16'h00C3);

        // Stray request in cycle 4, then a back-to-back write to confirm overrun is sticky
        applyStimulus(1'b1, 1'b0, 4'h5, 16'h1357, 16'h0000);
        checkOutput(0, 1, 2, 1, 4);
        applyStimulus(1'b1, 1'b0, 4'hC, 16'h2468, 16'h0000);
        checkOutput(0, 1, 2, 1, 0);
        checkIdle(0, 16'h00C3);

        // Reset lands on the edge ending the first cycle of the second strobe
        applyStimulus(1'b0, 1'b0, 4'h7, 16'h0000, 16'h5678);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            bus_data_i = (k == 3) ? 8'h56 : 8'h78;
            if (k == 6) reset = 1'b0;
        end
        @(negedge clk);
        checkReset(0);
        sb_q.delete();
        exp_ovr = 1'b0;
        reset = 1'b1;
        bus_data_i = 8'hEE;
        repeat (3) checkIdle(0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 4'h9, 16'h0000, 16'hBEEF);
        checkOutput(0, 1, 2, 1, 0);
        checkIdle(0, 16'hBEEF);

        // Wider timing on instance b
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkReset(1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h1, 16'hC0DE, 16'h0000);
        checkOutput(1, 2, 3, 2, 0);
        checkIdle(1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 4'h6, 16'h0000, 16'h9A3B);
        checkOutput(1, 2, 3, 2, 0);
        checkIdle(1, 16'h9A3B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
